// File: rtl/seg_scan_if.sv
// Bundles the display-data source side and the SEG/AN pin side of the scanner.
// The source drives data and the load strobe; the scanner drives the pins and status.
interface seg_scan_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] hex;
  logic [DIGITS-1:0]   en;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blink;
  logic                lz_en;
  logic                load;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame_done;
  logic                busy;

  modport master (
    output hex, en, dp, blink, lz_en, load,
    input  seg, an, frame_done, busy
  );

  modport slave (
    input  hex, en, dp, blink, lz_en, load,
    output seg, an, frame_done, busy
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with double-buffered display data, blink,
// leading-zero suppression and anti-ghost blanking at the start of each digit slot.
module seg_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYC    = 200,
  parameter int BLINK_FRAMES = 64,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit AN_ACT_LOW   = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  seg_scan_if.slave bus
);
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [7:0]        SEG_OFF   = {8{SEG_ACT_LOW}};
  localparam logic [DIGITS-1:0] AN_OFF    = {DIGITS{AN_ACT_LOW}};

  typedef struct packed {
    logic [4*DIGITS-1:0] hex;
    logic [DIGITS-1:0]   en;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blink;
    logic                lz_en;
  } disp_t;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h00;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FRM_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              blink_ph_q, blink_ph_d;
  logic              pending_q, pending_d;
  disp_t             staging_q, staging_d;
  disp_t             shadow_q, shadow_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  disp_t             in_cfg;
  logic              cnt_wrap;
  logic              boundary;

  assign in_cfg   = '{hex: bus.hex, en: bus.en, dp: bus.dp, blink: bus.blink, lz_en: bus.lz_en};
  assign cnt_wrap = (cnt_q == CNT_LAST);
  assign boundary = cnt_wrap && (idx_q == IDX_LAST);

  // Scan timing, blink phase and the staging/shadow handshake.
  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d       = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    blink_ph_d  = blink_ph_q;
    staging_d   = bus.load ? in_cfg : staging_q;
    shadow_d    = shadow_q;
    pending_d   = pending_q;

    if (cnt_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    if (boundary) begin
      if (frame_cnt_q == FRM_LAST) begin
        frame_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
      // A strobe on the boundary itself bypasses staging so it is never lost.
      pending_d = 1'b0;
      if (bus.load) begin
        shadow_d = in_cfg;
      end else if (pending_q) begin
        shadow_d = staging_q;
      end
    end else if (bus.load) begin
      pending_d = 1'b1;
    end
  end

  logic [3:0]        nib [DIGITS];
  logic [DIGITS-1:0] supp;
  logic [DIGITS-1:0] digit_on;
  logic              higher_zero;
  logic              cur_on;
  logic [7:0]        seg_raw;
  logic [DIGITS-1:0] an_raw;

  // Per-digit visibility, then select the current slot's digit for the output registers.
  always_comb begin
    higher_zero = 1'b1;
    supp        = '0;
    digit_on    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib[i]      = shadow_q.hex[4*i +: 4];
      supp[i]     = shadow_q.lz_en && (i != 0) && (nib[i] == 4'h0) && higher_zero;
      higher_zero = higher_zero && (!shadow_q.en[i] || (nib[i] == 4'h0));
      // A suppressed digit without its dp has nothing to show, so its anode stays off.
      digit_on[i] = shadow_q.en[i] && !(blink_ph_q && shadow_q.blink[i]) &&
                    !(supp[i] && !shadow_q.dp[i]);
    end

    cur_on  = digit_on[idx_q] && (cnt_q >= CNT_BLANK);
    seg_raw = 8'h00;
    an_raw  = '0;
    if (cur_on) begin
      seg_raw = {shadow_q.dp[idx_q], supp[idx_q] ? 7'h00 : hex7(nib[idx_q])};
    end
    for (int i = 0; i < DIGITS; i++) begin
      an_raw[i] = cur_on && (idx_q == IDX_W'(i));
    end

    seg_d = seg_raw ^ SEG_OFF;
    an_d  = an_raw ^ AN_OFF;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      pending_q   <= 1'b0;
      // NOTE: the data registers are reset too; a cleared shadow (en=0) is what keeps the display dark after reset.
      staging_q   <= '0;
      shadow_q    <= '0;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      blink_ph_q  <= blink_ph_d;
      pending_q   <= pending_d;
      staging_q   <= staging_d;
      shadow_q    <= shadow_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = boundary;
  assign bus.busy       = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus queues hand-computed digit presentations,
// a monitor pops one per lit digit slot and checks code, anode, blank gap and slot length.
module tb_seg_scan_ctrl;
  localparam int DIGITS = 4;
  localparam int SCAN   = 8;
  localparam int BLANK  = 2;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    int         gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  seg_scan_if #(.DIGITS(DIGITS)) ifc ();

  seg_scan_ctrl #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN), .BLANK_CYC(BLANK), .BLINK_FRAMES(2),
    .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [7:0] s, input int g);
    exp_t e;
    e.an = a; e.seg = s; e.gap = g;
    sb.push_back(e);
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifc.frame_done && n < 40);
    check("frame_done_seen", 32'(ifc.frame_done), 32'd1);
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] e, input logic [3:0] d,
                         input logic [3:0] b, input logic lz);
    @(posedge clk); #1;
    ifc.hex = h; ifc.en = e; ifc.dp = d; ifc.blink = b; ifc.lz_en = lz;
    ifc.load = 1'b1;
    @(posedge clk); #1;
    ifc.load = 1'b0;
    @(negedge clk);
    check("busy_after_load", 32'(ifc.busy), 32'd1);
  endtask

  // Called in the cycle after a boundary; watches n whole frames of the new data.
  task automatic watch(input int n);
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (n) wait_frame();
    @(posedge clk); #1;
    mon_en = 1'b0;
    check("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic apply_and_watch(input int n, input logic exp_busy);
    wait_frame();
    check("busy_at_boundary", 32'(ifc.busy), 32'(exp_busy));
    @(negedge clk);
    check("busy_after_boundary", 32'(ifc.busy), 32'd0);
    watch(n);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rst_an", 32'(ifc.an), 32'hF);
    check("rst_seg", 32'(ifc.seg), 32'hFF);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_frame_done", 32'(ifc.frame_done), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("busy_after_rst", 32'(ifc.busy), 32'd0);
  endtask

  // Monitor: one scoreboard entry per lit slot, plus slot shape checks while enabled.
  initial begin
    bit         prev_act = 1'b0;
    int         gap = 0;
    int         act_len = 0;
    logic [11:0] held = '0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (ifc.an !== 4'hF) begin
        if (!prev_act) begin
          held    = {ifc.an, ifc.seg};
          act_len = 1;
          if (mon_en) begin
            if (sb.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_digit: an=%h seg=%h with no entry expected at %0t",
                       ifc.an, ifc.seg, $time);
            end else begin
              e = sb.pop_front();
              check("digit_an", 32'(ifc.an), 32'(e.an));
              check("digit_seg", 32'(ifc.seg), 32'(e.seg));
              if (e.gap >= 0) check("blank_gap", gap, e.gap);
            end
          end
        end else begin
          act_len++;
          if (mon_en) check("digit_stable", 32'({ifc.an, ifc.seg}), 32'(held));
        end
        prev_act = 1'b1;
      end else begin
        if (prev_act) begin
          if (mon_en) check("slot_len", act_len, SCAN - BLANK);
          gap = 1;
        end else begin
          gap++;
        end
        if (mon_en) check("seg_dark", 32'(ifc.seg), 32'hFF);
        prev_act = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad = 0;
    int p0 = -1;
    int p1 = -1;
    int pulses = 0;

    ifc.hex = '0; ifc.en = '0; ifc.dp = '0; ifc.blink = '0; ifc.lz_en = 1'b0; ifc.load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("init_an", 32'(ifc.an), 32'hF);
    check("init_seg", 32'(ifc.seg), 32'hFF);
    check("init_busy", 32'(ifc.busy), 32'd0);
    check("init_frame_done", 32'(ifc.frame_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle after reset: dark outputs, frame_done every 32 cycles.
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (ifc.an !== 4'hF || ifc.seg !== 8'hFF) bad++;
      if (ifc.frame_done) begin
        pulses++;
        if (p0 < 0) p0 = c;
        else if (p1 < 0) p1 = c;
      end
    end
    check("idle_dark", bad, 0);
    check("idle_fd_first", p0, 31);
    check("idle_fd_period", p1 - p0, 32);
    check("idle_fd_pulses", pulses, 2);

    // "1234": each digit code, 2-cycle blank between slots.
    do_load(16'h1234, 4'hF, 4'h0, 4'h0, 1'b0);
    for (int f = 0; f < 2; f++) begin
      push(4'hE, 8'h99, (f == 0) ? -1 : 2);
      push(4'hD, 8'hB0, 2);
      push(4'hB, 8'hA4, 2);
      push(4'h7, 8'hF9, 2);
    end
    apply_and_watch(2, 1'b1);

    // "0050" with leading-zero suppression: digits 3 and 2 dark.
    do_load(16'h0050, 4'hF, 4'h0, 4'h0, 1'b1);
    push(4'hE, 8'hC0, -1); push(4'hD, 8'h92, 2);
    push(4'hE, 8'hC0, 18); push(4'hD, 8'h92, 2);
    apply_and_watch(2, 1'b1);

    // Suppressed digit 3 still shows its dp; digit 2 stays dark.
    do_load(16'h0050, 4'hF, 4'b1000, 4'h0, 1'b1);
    push(4'hE, 8'hC0, -1); push(4'hD, 8'h92, 2); push(4'h7, 8'h7F, 10);
    apply_and_watch(1, 1'b1);

    // Same data without suppression.
    do_load(16'h0050, 4'hF, 4'h0, 4'h0, 1'b0);
    push(4'hE, 8'hC0, -1); push(4'hD, 8'h92, 2); push(4'hB, 8'hC0, 2); push(4'h7, 8'hC0, 2);
    apply_and_watch(1, 1'b1);

    // Disabled nonzero top digit does not stop suppression below it; digit 0 always shows.
    do_load(16'h5000, 4'b0111, 4'h0, 4'h0, 1'b1);
    push(4'hE, 8'hC0, -1); push(4'hE, 8'hC0, 26);
    apply_and_watch(2, 1'b1);

    // Load A mid-frame, load B on the boundary cycle: only B appears.
    wait_frame();
    repeat (5) @(posedge clk);
    #1;
    ifc.hex = 16'hABCD; ifc.en = 4'hF; ifc.dp = 4'h0; ifc.blink = 4'h0; ifc.lz_en = 1'b0;
    ifc.load = 1'b1;
    @(posedge clk); #1;
    ifc.load = 1'b0;
    repeat (26) @(posedge clk);
    #1;
    ifc.hex = 16'hC0DE; ifc.dp = 4'b0010;
    ifc.load = 1'b1;
    push(4'hE, 8'h86, -1); push(4'hD, 8'h21, 2); push(4'hB, 8'hC0, 2); push(4'h7, 8'hC6, 2);
    @(negedge clk);
    check("b_on_boundary", 32'(ifc.frame_done), 32'd1);
    check("busy_before_b", 32'(ifc.busy), 32'd1);
    @(posedge clk); #1;
    ifc.load = 1'b0;
    @(negedge clk);
    check("busy_after_b", 32'(ifc.busy), 32'd0);
    watch(1);

    // Reset mid-slot with a load pending: pending and shadow discarded.
    do_load(16'h1234, 4'hF, 4'hF, 4'h0, 1'b0);
    repeat (10) @(posedge clk);
    do_reset();
    apply_and_watch(2, 1'b0);

    // Blink on digit 0 from a known phase: lit, dark, dark, lit, lit.
    do_reset();
    do_load(16'h1234, 4'hF, 4'h0, 4'b0001, 1'b0);
    push(4'hE, 8'h99, -1); push(4'hD, 8'hB0, 2); push(4'hB, 8'hA4, 2); push(4'h7, 8'hF9, 2);
    for (int f = 0; f < 2; f++) begin
      push(4'hD, 8'hB0, 10); push(4'hB, 8'hA4, 2); push(4'h7, 8'hF9, 2);
    end
    for (int f = 0; f < 2; f++) begin
      push(4'hE, 8'h99, 2); push(4'hD, 8'hB0, 2); push(4'hB, 8'hA4, 2); push(4'h7, 8'hF9, 2);
    end
    apply_and_watch(5, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
